// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parameter limits
// Purpose: receiver FSM state encoding and legal ranges for DATA_BITS / OVERSAMPLE.
// Ports: none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    localparam int unsigned DATA_BITS_MIN  = 5;
    localparam int unsigned DATA_BITS_MAX  = 9;
    localparam int unsigned OVERSAMPLE_MIN = 8;
    localparam int unsigned OVERSAMPLE_MAX = 32;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high serial line
// Purpose: brings the asynchronous rx line into the clk domain.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset (flops reset to 1 = line idle)
//   rx     in  asynchronous serial input
//   rx_s   out synchronised serial line
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
        end
    end

    assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with valid/ready output
// Purpose: detects start bit, samples DATA_BITS data bits (LSB first), optional
//   parity (macro UART_RX_PARITY_EN) and STOP_BITS stop bits at bit centres,
//   then presents the word with framing/parity status over valid/ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   baud_tick             1-clk pulse at OVERSAMPLE x baud
//   rx                    asynchronous serial line, idle high
//   parity_odd            1 = odd parity (parity build only)
//   rx_data/rx_valid      received word, held until rx_ready
//   rx_ready              consumer accept
//   frame_err/parity_err  status of the word in rx_data
//   overrun_err           1-clk pulse when a completed frame is dropped
//   busy                  receiver FSM not idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS out of range");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_core: OVERSAMPLE out of range or odd");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_core: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_q, frame_d;   // any stop sample low so far
    logic                 perr_q, perr_d;     // parity mismatch of frame in progress
    logic                 commit;
    logic                 frame_now;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q, perr_out_q, ovr_q;

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Includes the current stop sample so the committed flag covers every stop bit.
    assign frame_now = frame_q | ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        frame_d = frame_q;
        perr_d  = perr_q;
        commit  = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        bit_d  = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            frame_d = 1'b0;
                            perr_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        perr_d  = rx_s != ((^shift_q) ^ parity_odd);
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        frame_d = frame_now;
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            commit  = 1'b1;
                            // A low stop bit usually means a break: wait for idle before re-arming.
                            state_d = frame_now ? BREAK : IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (commit) begin
                // Slot is free if empty or being drained this very cycle.
                if (!valid_q || rx_ready) begin
                    data_q     <= shift_q;
                    ferr_q     <= frame_now;
                    perr_out_q <= perr_q;
                    valid_q    <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign parity_err  = perr_out_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core (8 data bits, x16, 1 stop)
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int TDIV = 4;            // clocks per baud_tick
    localparam int BIT  = 16 * TDIV;    // clocks per bit period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err, parity_err, overrun_err, busy;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv      = (tdiv + 1) % TDIV;
        baud_tick = (tdiv == 0);
    end

    int   vcnt = 0, vhigh = 0, ocnt = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !prev_v) vcnt++;
        if (rx_valid) vhigh++;
        if (overrun_err) ocnt++;
        prev_v = rx_valid;
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_lvl,
                              input logic stop_lvl, input logic idle_lvl);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = par_lvl;
            repeat (BIT) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (BIT) @(negedge clk);
        rx = idle_lvl;
        repeat (BIT) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic       par_flip;
        logic       stop_lvl;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, h0, o0;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, PAR_EN};
        vecs[6] = '{8'h07, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'h6E, 1'b1, 1'b1, 1'b1, 8'h6E, 1'b0, PAR_EN};

        repeat (4) @(negedge clk);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset parity_err", parity_err, 0);
        chk("reset overrun_err", overrun_err, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            v0 = vcnt;
            h0 = vhigh;
            parity_odd = vecs[i].odd;
            send_frame(vecs[i].data, (^vecs[i].data) ^ vecs[i].odd ^ vecs[i].par_flip,
                       vecs[i].stop_lvl, 1'b1);
            chk($sformatf("vec%0d valid count", i), vcnt - v0, 1);
            chk($sformatf("vec%0d valid width", i), vhigh - h0, 1);
            chk($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
            chk($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_ferr);
            chk($sformatf("vec%0d parity_err", i), parity_err, vecs[i].exp_perr);
            chk($sformatf("vec%0d busy idle", i), busy, 0);
        end
        parity_odd = 1'b0;

        // Short start glitch: 4 ticks low, must abort without output.
        v0 = vcnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch busy in start", busy, 1);
        repeat (3 * BIT) @(negedge clk);
        chk("glitch busy dropped", busy, 0);
        chk("glitch no valid", vcnt - v0, 0);

        // Stop bit low with line held low: one frame, then stuck in break.
        v0 = vcnt;
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        repeat (6 * BIT) @(negedge clk);
        chk("break valid count", vcnt - v0, 1);
        chk("break rx_data", rx_data, 8'h3C);
        chk("break frame_err", frame_err, 1);
        chk("break busy held", busy, 1);
        rx = 1'b1;
        repeat (3 * TDIV + 4) @(negedge clk);
        chk("break exit busy", busy, 0);
        repeat (BIT) @(negedge clk);

        // Overrun: consumer stalled across two frames.
        rx_ready = 1'b0;
        o0 = ocnt;
        send_frame(8'h11, ^8'h11, 1'b1, 1'b1);
        chk("ovr first valid", rx_valid, 1);
        chk("ovr first data", rx_data, 8'h11);
        chk("ovr none yet", ocnt - o0, 0);
        send_frame(8'h22, ^8'h22, 1'b1, 1'b1);
        chk("ovr pulse count", ocnt - o0, 1);
        chk("ovr data kept", rx_data, 8'h11);
        chk("ovr valid held", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("ovr drained valid", rx_valid, 0);
        chk("ovr drained data", rx_data, 8'h11);
        rx_ready = 1'b1;
        repeat (BIT) @(negedge clk);

        // Reset in the middle of the data bits of 0xFF.
        v0 = vcnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("rst pre busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst rx_valid", rx_valid, 0);
        chk("rst rx_data", rx_data, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst busy", busy, 0);
        repeat (8 * BIT) @(negedge clk);
        chk("rst no output", vcnt - v0, 0);
        send_frame(8'h5A, ^8'h5A, 1'b1, 1'b1);
        chk("post rst valid count", vcnt - v0, 1);
        chk("post rst rx_data", rx_data, 8'h5A);
        chk("post rst frame_err", frame_err, 0);
        chk("post rst parity_err", parity_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
